uart_cmd_ctrl: RTL and testbench

//  Sequences the 8N1 UART receiver and assembles its byte stream into command frames.

---
 rtl/uart_cmd_pkg.sv | 26 ++
 rtl/uart_rx_timeout.sv | 29 ++
 rtl/uart_cmd_ctrl.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        DATA,
        CSUM,
        HOLD
    } state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CSUM    = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;

    // States in which a frame is partially received and the inter-byte timer runs.
    function automatic logic in_frame(input state_t s);
        return (s == CMD) || (s == LEN) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte timeout counter: saturates at TIMEOUT_CYC and flags expiry while enabled.
module uart_rx_timeout #(
    parameter int TIMEOUT_CYC = 52080
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + W'(1);
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles UART bytes into SYNC/CMD/LEN/payload/CSUM frames, validates them
// and holds a good frame until the consumer acknowledges it.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter  int MAX_LEN     = 16,
    parameter  int TIMEOUT_CYC = 52080,
    localparam int AW          = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_rdy,
    output logic          clr_rdy,
    output logic          frame_vld,
    input  logic          frame_ack,
    output logic [7:0]    cmd,
    output logic [7:0]    len,
    input  logic [AW-1:0] pl_raddr,
    output logic [7:0]    pl_rdata,
    output logic          err_vld,
    output logic [2:0]    err_code
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t        state;
    logic [7:0]    sum;
    logic [7:0]    sum_next;
    logic [7:0]    len_m1;
    logic [AW-1:0] idx;
    logic [7:0]    payload [MAX_LEN];
    logic          accept;
    logic          expired;
    logic          wr_en;

    // rx_rdy stays high until our clear lands, so the cycle after an accept is masked.
    assign accept   = rx_rdy && !clr_rdy;
    assign sum_next = sum + rx_data;
    assign len_m1   = len - 8'd1;
    assign wr_en    = accept && !expired && (state == DATA);

    uart_rx_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .enable  (in_frame(state)),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clr_rdy   <= 1'b0;
            frame_vld <= 1'b0;
            err_vld   <= 1'b0;
            err_code  <= ERR_NONE;
            cmd       <= 8'd0;
            len       <= 8'd0;
            sum       <= 8'd0;
            idx       <= '0;
        end else begin
            clr_rdy  <= accept;
            err_vld  <= 1'b0;
            err_code <= ERR_NONE;
            // Expiry beats a byte arriving in the same cycle; that byte is cleared and lost.
            if (expired) begin
                err_vld  <= 1'b1;
                err_code <= ERR_TIMEOUT;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept && (rx_data == SYNC_BYTE)) begin
                            state <= CMD;
                        end
                    end
                    CMD: begin
                        if (accept) begin
                            cmd   <= rx_data;
                            sum   <= rx_data;
                            state <= LEN;
                        end
                    end
                    LEN: begin
                        if (accept) begin
                            if (rx_data > MAX_LEN_B) begin
                                err_vld  <= 1'b1;
                                err_code <= ERR_LEN;
                                state    <= IDLE;
                            end else begin
                                len   <= rx_data;
                                sum   <= sum_next;
                                idx   <= '0;
                                state <= (rx_data == 8'd0) ? CSUM : DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            sum <= sum_next;
                            idx <= idx + AW'(1);
                            if (8'(idx) == len_m1) begin
                                state <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (accept) begin
                            if (sum_next == 8'd0) begin
                                frame_vld <= 1'b1;
                                state     <= HOLD;
                            end else begin
                                err_vld  <= 1'b1;
                                err_code <= ERR_CSUM;
                                state    <= IDLE;
                            end
                        end
                    end
                    HOLD: begin
                        // An ack releases the frame and lets a same-cycle byte start the next one.
                        if (frame_ack) begin
                            frame_vld <= 1'b0;
                            state     <= (accept && (rx_data == SYNC_BYTE)) ? CMD : IDLE;
                        end else if (accept) begin
                            err_vld  <= 1'b1;
                            err_code <= ERR_OVERRUN;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Payload storage is deliberately left unreset; only indices below len are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            payload[idx] <= rx_data;
        end
    end

    assign pl_rdata = payload[pl_raddr];

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench: directed frame table, corner sequences and random frames vs a queue-based model.
module tb_uart_cmd_ctrl;

    localparam int MAX_LEN = 16;
    localparam int T       = 40;
    localparam int AW      = $clog2(MAX_LEN);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_rdy = 1'b0;
    logic          clr_rdy;
    logic          frame_vld;
    logic          frame_ack = 1'b0;
    logic [7:0]    cmd;
    logic [7:0]    len;
    logic [AW-1:0] pl_raddr = '0;
    logic [7:0]    pl_rdata;
    logic          err_vld;
    logic [2:0]    err_code;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int clr_pulses = 0;
    int code_glitches = 0;
    int bytes_sent = 0;

    typedef struct {
        int c;
        int code;
    } err_ev_t;

    err_ev_t obs_q[$];
    err_ev_t exp_q[$];

    // Reference model state: bytes of the frame in progress, plus the held frame.
    logic [7:0] part_q[$];
    logic [7:0] hold_pl[$];
    logic [7:0] hold_cmd;
    logic [7:0] hold_len;
    bit         held = 1'b0;
    int         last_acc = 0;

    typedef struct {
        int           n;
        logic [159:0] data;
        bit           exp_vld;
        logic [7:0]   exp_cmd;
        logic [7:0]   exp_len;
        int           exp_err;
    } vec_t;

    vec_t vecs[6];

    uart_cmd_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .clr_rdy   (clr_rdy),
        .frame_vld (frame_vld),
        .frame_ack (frame_ack),
        .cmd       (cmd),
        .len       (len),
        .pl_raddr  (pl_raddr),
        .pl_rdata  (pl_rdata),
        .err_vld   (err_vld),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void pushObs(input int c, input int code);
        err_ev_t e;
        e.c = c;
        e.code = code;
        obs_q.push_back(e);
    endfunction

    function automatic void expErr(input int c, input int code);
        err_ev_t e;
        e.c = c;
        e.code = code;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (clr_rdy) clr_pulses <= clr_pulses + 1;
        if (!err_vld && (err_code != 3'd0)) code_glitches <= code_glitches + 1;
        if (err_vld) pushObs(cyc, int'(err_code));
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelTimeout(input int now);
        if ((part_q.size() != 0) && (now >= last_acc + T + 1)) begin
            expErr(last_acc + T + 1, 3);
            part_q.delete();
        end
    endtask

    task automatic modelByte(input logic [7:0] b, input int a);
        int g;
        int n;
        int s;
        bit was_in_frame;
        g = a - last_acc;
        was_in_frame = (part_q.size() != 0);
        modelTimeout(a);
        last_acc = a;
        if (was_in_frame && (g == T + 1)) return;
        if (held) begin
            expErr(a, 4);
            return;
        end
        if (part_q.size() == 0) begin
            if (b == 8'hA5) part_q.push_back(b);
            return;
        end
        part_q.push_back(b);
        n = part_q.size();
        if ((n == 3) && (int'(part_q[2]) > MAX_LEN)) begin
            expErr(a, 2);
            part_q.delete();
        end else if ((n >= 4) && (n == 4 + int'(part_q[2]))) begin
            s = 0;
            for (int i = 1; i < n; i++) s += int'(part_q[i]);
            if ((s % 256) == 0) begin
                held = 1'b1;
                hold_cmd = part_q[1];
                hold_len = part_q[2];
                hold_pl.delete();
                for (int i = 3; i < n - 1; i++) hold_pl.push_back(part_q[i]);
            end else begin
                expErr(a, 1);
            end
            part_q.delete();
        end
    endtask

    // Presents one byte after 'idle' quiet cycles; hold=1 keeps rx_rdy up one extra cycle.
    task automatic applyStimulus(input logic [7:0] b, input int idle, input bit hold);
        int waited;
        repeat (idle) step();
        rx_data = b;
        rx_rdy = 1'b1;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!clr_rdy && (waited < 8));
        checkOutput("accept_latency", waited, 1);
        modelByte(b, cyc);
        if (hold) step();
        rx_rdy = 1'b0;
        bytes_sent++;
    endtask

    task automatic drainErrors();
        err_ev_t e;
        err_ev_t o;
        modelTimeout(cyc);
        while ((exp_q.size() != 0) && (obs_q.size() != 0)) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checkOutput("err_cycle", o.c, e.c);
            checkOutput("err_code", o.code, e.code);
        end
        checkOutput("err_unexpected", obs_q.size(), 0);
        checkOutput("err_missing", exp_q.size(), 0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "_frame_vld"}, frame_vld, held);
        if (held) begin
            checkOutput({tag, "_cmd"}, cmd, hold_cmd);
            checkOutput({tag, "_len"}, len, hold_len);
            for (int i = 0; i < hold_pl.size(); i++) begin
                pl_raddr = AW'(i);
                step();
                checkOutput({tag, "_payload"}, pl_rdata, hold_pl[i]);
            end
        end
    endtask

    task automatic ackFrame();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        held = 1'b0;
        checkOutput("ack_clears_vld", frame_vld, 0);
    endtask

    task automatic ackWithByte(input logic [7:0] b);
        frame_ack = 1'b1;
        rx_data = b;
        rx_rdy = 1'b1;
        step();
        frame_ack = 1'b0;
        checkOutput("ackbyte_clr_rdy", clr_rdy, 1);
        checkOutput("ackbyte_frame_vld", frame_vld, 0);
        held = 1'b0;
        modelByte(b, cyc);
        rx_rdy = 1'b0;
        bytes_sent++;
    endtask

    task automatic sendGood(input logic [7:0] c, input int n, input int idle);
        int s;
        logic [7:0] p;
        s = int'(c) + n;
        applyStimulus(8'hA5, idle, 1'b0);
        applyStimulus(c, idle, 1'b0);
        applyStimulus(8'(n), idle, 1'b0);
        for (int i = 0; i < n; i++) begin
            p = 8'($urandom);
            s += int'(p);
            applyStimulus(p, idle, 1'b0);
        end
        applyStimulus(8'((256 - (s % 256)) % 256), idle, 1'b0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_frame_vld"}, frame_vld, 0);
        checkOutput({tag, "_err_vld"}, err_vld, 0);
        checkOutput({tag, "_err_code"}, err_code, 0);
        checkOutput({tag, "_cmd"}, cmd, 0);
        checkOutput({tag, "_len"}, len, 0);
        checkOutput({tag, "_clr_rdy"}, clr_rdy, 0);
    endtask

    initial begin
        int start;
        int last_code;
        int t0;
        int kind;
        int n;
        int s;
        int idle;
        logic [7:0] b;
        logic [7:0] fr[$];

        vecs[0] = '{n: 6, data: 160'({8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'hCD}),
                    exp_vld: 1'b1, exp_cmd: 8'h01, exp_len: 8'h02, exp_err: 0};
        vecs[1] = '{n: 6, data: 160'({8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'hCC}),
                    exp_vld: 1'b0, exp_cmd: 8'h00, exp_len: 8'h00, exp_err: 1};
        vecs[2] = '{n: 6, data: 160'({8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'hF9}),
                    exp_vld: 1'b1, exp_cmd: 8'h07, exp_len: 8'h00, exp_err: 0};
        vecs[3] = '{n: 3, data: 160'({8'hA5, 8'h01, 8'h11}),
                    exp_vld: 1'b0, exp_cmd: 8'h00, exp_len: 8'h00, exp_err: 2};
        vecs[4] = '{n: 4, data: 160'({8'hA5, 8'h03, 8'h00, 8'hFD}),
                    exp_vld: 1'b1, exp_cmd: 8'h03, exp_len: 8'h00, exp_err: 0};
        vecs[5] = '{n: 20, data: {8'hA5, 8'h10, 8'h10, 128'h000102030405060708090A0B0C0D0E0F, 8'h68},
                    exp_vld: 1'b1, exp_cmd: 8'h10, exp_len: 8'h10, exp_err: 0};

        step();
        step();
        checkResetOutputs("reset");
        rst_n = 1'b1;
        step();
        checkResetOutputs("post_reset");

        for (int k = 0; k < 6; k++) begin
            start = obs_q.size();
            for (int i = 0; i < vecs[k].n; i++) begin
                applyStimulus(vecs[k].data[8*(vecs[k].n-1-i) +: 8], 2, (i % 3) == 1);
            end
            step();
            last_code = (obs_q.size() > start) ? obs_q[obs_q.size()-1].code : 0;
            checkOutput($sformatf("vec%0d_frame_vld", k), frame_vld, vecs[k].exp_vld);
            checkOutput($sformatf("vec%0d_err", k), last_code, vecs[k].exp_err);
            if (vecs[k].exp_vld) begin
                checkOutput($sformatf("vec%0d_cmd", k), cmd, vecs[k].exp_cmd);
                checkOutput($sformatf("vec%0d_len", k), len, vecs[k].exp_len);
            end
            checkFrame($sformatf("vec%0d_model", k));
            if (held) ackFrame();
            drainErrors();
        end

        $display("[TB] timeout at exact expiry");
        applyStimulus(8'hA5, 2, 1'b0);
        applyStimulus(8'h01, 2, 1'b0);
        t0 = cyc;
        for (int i = 0; (i < T + 10) && !err_vld; i++) step();
        checkOutput("timeout_delay", cyc - t0, T + 1);
        checkOutput("timeout_code", err_code, 3);
        drainErrors();
        foreach (vecs[4].data[i]) begin end
        applyStimulus(8'hA5, 2, 1'b0);
        applyStimulus(8'h03, 2, 1'b0);
        applyStimulus(8'h00, 2, 1'b0);
        applyStimulus(8'hFD, 2, 1'b0);
        checkFrame("after_timeout");
        if (held) ackFrame();
        drainErrors();

        $display("[TB] byte exactly at expiry, and one cycle earlier");
        applyStimulus(8'hA5, 2, 1'b0);
        applyStimulus(8'h01, T, 1'b0);
        applyStimulus(8'hA5, 2, 1'b0);
        applyStimulus(8'h03, 2, 1'b0);
        applyStimulus(8'h00, 2, 1'b0);
        applyStimulus(8'hFD, 2, 1'b0);
        checkFrame("edge_drop");
        if (held) ackFrame();
        drainErrors();
        applyStimulus(8'hA5, 2, 1'b0);
        applyStimulus(8'h01, T - 1, 1'b0);
        applyStimulus(8'h00, 2, 1'b0);
        applyStimulus(8'hFF, 2, 1'b0);
        checkFrame("edge_keep");
        if (held) ackFrame();
        drainErrors();

        $display("[TB] overrun while holding");
        applyStimulus(8'hA5, 1, 1'b0);
        applyStimulus(8'h01, 1, 1'b0);
        applyStimulus(8'h02, 1, 1'b0);
        applyStimulus(8'h10, 1, 1'b0);
        applyStimulus(8'h20, 1, 1'b0);
        applyStimulus(8'hCD, 1, 1'b0);
        checkFrame("pre_overrun");
        applyStimulus(8'h55, 2, 1'b0);
        checkOutput("overrun_err_vld", err_vld, 1);
        checkOutput("overrun_code", err_code, 4);
        checkFrame("post_overrun");
        drainErrors();

        $display("[TB] ack and sync byte in the same cycle");
        ackWithByte(8'hA5);
        applyStimulus(8'h03, 2, 1'b0);
        applyStimulus(8'h00, 2, 1'b0);
        applyStimulus(8'hFD, 2, 1'b0);
        checkFrame("ack_byte");
        if (held) ackFrame();
        drainErrors();

        $display("[TB] reset in the middle of payload");
        applyStimulus(8'hA5, 2, 1'b0);
        applyStimulus(8'h01, 2, 1'b0);
        applyStimulus(8'h04, 2, 1'b0);
        applyStimulus(8'h11, 2, 1'b0);
        applyStimulus(8'h22, 2, 1'b0);
        drainErrors();
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid_reset");
        part_q.delete();
        held = 1'b0;
        step();
        rst_n = 1'b1;
        sendGood(8'h42, 3, 2);
        checkFrame("after_reset");
        if (held) ackFrame();
        drainErrors();

        $display("[TB] random frames");
        for (int it = 0; it < 40; it++) begin
            fr.delete();
            kind = $urandom_range(0, 4);
            if (kind == 3) begin
                repeat ($urandom_range(1, 3)) begin
                    b = 8'($urandom);
                    fr.push_back((b == 8'hA5) ? 8'h5A : b);
                end
            end
            fr.push_back(8'hA5);
            fr.push_back(8'($urandom));
            if (kind == 2) begin
                fr.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                n = $urandom_range(0, MAX_LEN);
                s = int'(fr[fr.size()-1]) + n;
                fr.push_back(8'(n));
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    s += int'(b);
                    fr.push_back(b);
                end
                b = 8'((256 - (s % 256)) % 256);
                fr.push_back((kind == 1) ? b + 8'($urandom_range(1, 255)) : b);
                if (kind == 4) begin
                    repeat ($urandom_range(1, n + 2)) void'(fr.pop_back());
                end
            end
            foreach (fr[i]) begin
                idle = ($urandom_range(0, 15) == 0) ? $urandom_range(T - 2, T + 4) : $urandom_range(1, 3);
                applyStimulus(fr[i], idle, $urandom_range(0, 3) == 0);
            end
            repeat (3) step();
            checkFrame($sformatf("rand%0d", it));
            if (held) begin
                if ($urandom_range(0, 1) == 1) begin
                    applyStimulus(8'($urandom), 1, 1'b0);
                    checkFrame($sformatf("rand%0d_overrun", it));
                end
                ackFrame();
            end
            repeat (T + 3) step();
            drainErrors();
        end

        checkOutput("clr_rdy_pulses", clr_pulses, bytes_sent);
        checkOutput("err_code_idle_zero", code_glitches, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
